fifo_dest_router: RTL

//  Push-side counterpart of the 4-FIFO round-robin arbiter. Takes the single arbitrated word stream
//  and steers each word to one of four output FIFOs (F0..F3), selected by the word's destination field.

---
 rtl/router_defs.sv | 14 +
 rtl/router_hold_reg.sv | 30 +++
 rtl/fifo_dest_router.sv | 118 +++++++++++
 3 files changed

// File: rtl/router_defs.sv
// Shared definitions for the destination router: port count, word layout and FSM encodings.
package router_defs;
  localparam int N_PORTS  = 4;
  localparam int DATA_W   = 10;
  localparam int DEST_MSB = DATA_W - 1;
  localparam int DEST_LSB = DATA_W - 2;
  localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } state_e;
endpackage

// File: rtl/router_hold_reg.sv
// Holding register H: one word plus valid, with its destination field decoded.
module router_hold_reg #(
  parameter int W = router_defs::DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          clear,
  input  logic [W-1:0]                  d,
  output logic [W-1:0]                  q,
  output logic                          vld,
  output logic [router_defs::DEST_W-1:0] dest
);
  import router_defs::*;

  // load wins over clear so a drain and reload can share an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end else if (clear) begin
      vld <= 1'b0;
    end
  end

  assign dest = q[W-1 -: DEST_W];
endmodule

// File: rtl/fifo_dest_router.sv
// Steers the arbitrated word stream into four output FIFOs by destination field.
// Optional stall timeout with drop counter is enabled by defining ROUTER_TIMEOUT_EN.
module fifo_dest_router #(
  parameter int DATA_W = router_defs::DATA_W
`ifdef ROUTER_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  input  logic              almost_full_P0,
  input  logic              almost_full_P1,
  input  logic              almost_full_P2,
  input  logic              almost_full_P3,
  output logic              push_F0,
  output logic              push_F1,
  output logic              push_F2,
  output logic              push_F3,
  output logic [DATA_W-1:0] out_FIFO_0,
  output logic [DATA_W-1:0] out_FIFO_1,
  output logic [DATA_W-1:0] out_FIFO_2,
  output logic [DATA_W-1:0] out_FIFO_3
`ifdef ROUTER_TIMEOUT_EN
  , output logic [7:0]      drop_cnt
`endif
);
  import router_defs::*;

  logic [N_PORTS-1:0]             af;
  logic                           h_vld;
  logic [DATA_W-1:0]              h_data;
  logic [DEST_W-1:0]              h_dest, in_dest;
  logic                           blocked, drain, drop, load, clear;
  logic [N_PORTS-1:0]             push_q;
  logic [N_PORTS-1:0][DATA_W-1:0] out_q;
  state_e                         state_q, state_d;

  assign af      = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
  assign in_dest = data_in[DATA_W-1 -: DEST_W];

  // only the flag of H's destination matters; other flags are don't-care
  assign blocked  = h_vld && af[h_dest];
  assign drain    = h_vld && !af[h_dest];
  assign ready_in = !reset && (!h_vld || drain || drop);
  assign load     = valid_in && ready_in;
  assign clear    = drain || drop;

  router_hold_reg #(.W(DATA_W)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .clear (clear),
    .d     (data_in),
    .q     (h_data),
    .vld   (h_vld),
    .dest  (h_dest)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = af[in_dest] ? ST_STALL : ST_SEND;
      ST_SEND, ST_STALL: begin
        if (load)       state_d = af[in_dest] ? ST_STALL : ST_SEND;
        else if (clear) state_d = ST_EMPTY;
        else            state_d = ST_STALL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // registered push: the word leaves H on the same edge its push strobe rises
  always_ff @(posedge clk) begin
    if (reset) begin
      push_q <= '0;
      out_q  <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        push_q[p] <= drain && (h_dest == DEST_W'(p));
        if (drain && (h_dest == DEST_W'(p))) out_q[p] <= h_data;
      end
    end
  end

  assign {push_F3, push_F2, push_F1, push_F0} = push_q;
  assign out_FIFO_0 = out_q[0];
  assign out_FIFO_1 = out_q[1];
  assign out_FIFO_2 = out_q[2];
  assign out_FIFO_3 = out_q[3];

`ifdef ROUTER_TIMEOUT_EN
  logic [7:0] stall_cnt, drop_cnt_q;

  assign drop     = (state_q == ST_STALL) && blocked && (stall_cnt == 8'(TIMEOUT - 1));
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if ((state_q == ST_STALL) && blocked && !drop) stall_cnt <= stall_cnt + 8'd1;
      else                                            stall_cnt <= '0;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`else
  assign drop = 1'b0;
`endif
endmodule
